player_collision: RTL and testbench

- Producer of the 4-bit `playerCol` vector that the player physics block consumes.
- On each physics step it samples the packed `playerState` and computes the position the player will reach next.
- It probes the tile map at the leading edges of the player box, then returns registered left/bottom/right/top collision flags with a one-cycle valid strobe.
- It sits between the player block and the tile-map ROM/RAM read port.

---
 rtl/player_collision.sv | 202 ++++++++++++++++++++
 tb/tb_player_collision.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/player_collision.sv
// player_collision: predicts the player's next position from the packed
// playerState, probes the tile map at the leading edges of the player box
// (two probes per moving axis) and returns registered left/bottom/right/top
// collision flags together with a one-cycle valid strobe.
module player_collision #(
  parameter int ORIGIN_X   = 144,
  parameter int ORIGIN_Y   = 35,
  parameter int TILE_SHIFT = 5,
  parameter int MAP_COLS   = 20,
  parameter int MAP_ROWS   = 15,
  parameter int PLAYER_W   = 32,
  parameter int PLAYER_H   = 32
) (
  input  logic        sim_clk,
  input  logic        reset,
  input  logic        step,
  input  logic [31:0] playerState,
  output logic [8:0]  tile_addr,
  output logic        tile_re,
  input  logic        tile_solid,
  output logic [3:0]  playerCol,
  output logic        col_valid,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  localparam logic [9:0] OX    = 10'(ORIGIN_X);
  localparam logic [9:0] OY    = 10'(ORIGIN_Y);
  localparam logic [9:0] W_M1  = 10'(PLAYER_W - 1);
  localparam logic [9:0] H_M1  = 10'(PLAYER_H - 1);
  localparam logic [9:0] NCOLS = 10'(MAP_COLS);
  localparam logic [9:0] NROWS = 10'(MAP_ROWS);

  state_t      state_q, state_d;
  logic [1:0]  k_q, k_d;
  logic [31:0] ps_q;

  // Decoded fields of the latched player state
  logic [9:0]  x_pos, y_pos, x_spd, y_spd;
  logic        x_right, y_up;

  // Predicted position and the currently addressed probe point
  logic [9:0]  nx, ny, px, py;
  logic [9:0]  dx, dy, col_c, row_c;
  logic        probe_skip, probe_oof, probe_read, probe_force;
  logic [8:0]  probe_addr;

  // Two-stage tag pipe that follows each probe until its tile_solid arrives
  logic        s1_vld, s1_read, s1_force;
  logic [1:0]  s1_idx;
  logic        s2_vld, s2_read, s2_force;
  logic [1:0]  s2_idx;

  logic [3:0]  hits_q, hits_d;
  logic        h_hit, v_hit;
  logic [3:0]  col_d;

  // FSM control
  logic        accept, issue_en, busy_d, valid_d, load_col;

  assign x_pos   = ps_q[31:22];
  assign y_pos   = ps_q[21:12];
  assign x_spd   = {5'b0, ps_q[11:7]};
  assign y_spd   = {5'b0, ps_q[6:2]};
  assign x_right = ps_q[1];
  assign y_up    = ps_q[0];

  // Predicted position (10-bit wrap) and probe point selection for probe k
  always_comb begin
    nx = x_right ? (x_pos + x_spd) : (x_pos - x_spd);
    ny = y_up    ? (y_pos - y_spd) : (y_pos + y_spd);
    px = '0;
    py = '0;
    unique case (k_q)
      2'd0: begin
        px = x_right ? (nx + W_M1) : nx;
        py = y_pos;
      end
      2'd1: begin
        px = x_right ? (nx + W_M1) : nx;
        py = y_pos + H_M1;
      end
      2'd2: begin
        px = x_pos;
        py = y_up ? ny : (ny + H_M1);
      end
      default: begin
        px = x_pos + W_M1;
        py = y_up ? ny : (ny + H_M1);
      end
    endcase
  end

  // Map the probe point to a tile, flag out-of-field and skipped probes
  always_comb begin
    dx          = px - OX;
    dy          = py - OY;
    col_c       = dx >> TILE_SHIFT;
    row_c       = dy >> TILE_SHIFT;
    probe_oof   = (px < OX) || (py < OY) || (col_c >= NCOLS) || (row_c >= NROWS);
    probe_skip  = k_q[1] ? (y_spd == '0) : (x_spd == '0);
    probe_read  = !probe_skip && !probe_oof;
    probe_force = !probe_skip && probe_oof;
    probe_addr  = 9'(row_c) * 9'(MAP_COLS) + 9'(col_c);
  end

  // Merge the probe result arriving this cycle and assemble the flag vector
  always_comb begin
    hits_d = hits_q;
    if (s2_vld) begin
      hits_d[s2_idx] = s2_read ? tile_solid : s2_force;
    end
    h_hit = hits_d[0] | hits_d[1];
    v_hit = hits_d[2] | hits_d[3];
    col_d = {y_up & v_hit, x_right & h_hit, ~y_up & v_hit, ~x_right & h_hit};
  end

  // Next-state logic and per-state control strobes
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    accept   = 1'b0;
    issue_en = 1'b0;
    busy_d   = 1'b0;
    valid_d  = 1'b0;
    load_col = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (step) begin
          accept  = 1'b1;
          k_d     = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        issue_en = 1'b1;
        busy_d   = 1'b1;
        k_d      = k_q + 2'd1;
        if (k_q == 2'd3) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        busy_d  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        load_col = 1'b1;
        valid_d  = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, probe issue, result capture and output registers
  always_ff @(posedge sim_clk) begin
    if (reset) begin
      state_q   <= IDLE;
      k_q       <= '0;
      ps_q      <= '0;
      tile_addr <= '0;
      tile_re   <= 1'b0;
      s1_vld    <= 1'b0;
      s1_read   <= 1'b0;
      s1_force  <= 1'b0;
      s1_idx    <= '0;
      s2_vld    <= 1'b0;
      s2_read   <= 1'b0;
      s2_force  <= 1'b0;
      s2_idx    <= '0;
      hits_q    <= '0;
      playerCol <= '0;
      col_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      busy      <= busy_d;
      col_valid <= valid_d;
      if (accept) begin
        ps_q <= playerState;
      end
      tile_re   <= issue_en && probe_read;
      tile_addr <= (issue_en && probe_read) ? probe_addr : '0;
      s1_vld    <= issue_en;
      s1_read   <= probe_read;
      s1_force  <= probe_force;
      s1_idx    <= k_q;
      s2_vld    <= s1_vld;
      s2_read   <= s1_read;
      s2_force  <= s1_force;
      s2_idx    <= s1_idx;
      hits_q    <= accept ? '0 : hits_d;
      if (load_col) begin
        playerCol <= col_d;
      end
    end
  end

endmodule

// File: tb/tb_player_collision.sv
// Directed bench for player_collision: a tile-map ROM model with one-cycle
// read latency, a reference model that pushes expected results to a queue
// when a query is driven, and cycle-exact checks of the probe/result timing.
module tb_player_collision;

  logic        sim_clk = 1'b0;
  logic        reset;
  logic        step;
  logic [31:0] playerState;
  logic [8:0]  tile_addr;
  logic        tile_re;
  logic        tile_solid;
  logic [3:0]  playerCol;
  logic        col_valid;
  logic        busy;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  bit tmap [0:299];

  typedef struct packed {
    logic [3:0]  col;
    logic [3:0]  re;
    logic [35:0] addr;
  } exp_t;

  exp_t exp_q [$];

  player_collision #(
    .ORIGIN_X(144), .ORIGIN_Y(35), .TILE_SHIFT(5), .MAP_COLS(20),
    .MAP_ROWS(15), .PLAYER_W(32), .PLAYER_H(32)
  ) dut (
    .sim_clk(sim_clk), .reset(reset), .step(step), .playerState(playerState),
    .tile_addr(tile_addr), .tile_re(tile_re), .tile_solid(tile_solid),
    .playerCol(playerCol), .col_valid(col_valid), .busy(busy)
  );

  always #5 sim_clk = ~sim_clk;

  // Tile ROM: answers one cycle after the address; idle cycles return 1 so a
  // result taken from a non-issued probe shows up as a false hit.
  always @(posedge sim_clk) begin
    if (tile_re) tile_solid <= (int'(tile_addr) < 300) ? tmap[tile_addr] : 1'b0;
    else         tile_solid <= 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
  endtask

  function automatic logic [31:0] mk(input int x, input int y, input int xs,
                                     input int ys, input bit xr, input bit yu);
    return {10'(x), 10'(y), 5'(xs), 5'(ys), xr, yu};
  endfunction

  // Reference model: integer arithmetic with explicit mod-1024 wrap
  function automatic exp_t model(input logic [31:0] st);
    exp_t e;
    int x, y, xs, ys, nx, ny, cx, ry;
    bit xr, yu, skip, oof;
    int px [4];
    int py [4];
    bit s [4];
    x  = int'(st[31:22]);
    y  = int'(st[21:12]);
    xs = int'(st[11:7]);
    ys = int'(st[6:2]);
    xr = st[1];
    yu = st[0];
    nx = xr ? (x + xs) % 1024 : (x - xs + 1024) % 1024;
    ny = yu ? (y - ys + 1024) % 1024 : (y + ys) % 1024;
    px[0] = xr ? (nx + 31) % 1024 : nx;
    px[1] = px[0];
    py[0] = y;
    py[1] = (y + 31) % 1024;
    py[2] = yu ? ny : (ny + 31) % 1024;
    py[3] = py[2];
    px[2] = x;
    px[3] = (x + 31) % 1024;
    e = '0;
    for (int i = 0; i < 4; i++) begin
      skip = (i < 2) ? (xs == 0) : (ys == 0);
      cx   = (px[i] - 144) / 32;
      ry   = (py[i] - 35) / 32;
      oof  = (px[i] < 144) || (py[i] < 35) || (cx >= 20) || (ry >= 15);
      if (skip)     s[i] = 1'b0;
      else if (oof) s[i] = 1'b1;
      else begin
        e.re[i]          = 1'b1;
        e.addr[i*9 +: 9] = 9'(ry * 20 + cx);
        s[i]             = tmap[ry * 20 + cx];
      end
    end
    e.col = {yu & (s[2] | s[3]), xr & (s[0] | s[1]),
             !yu & (s[2] | s[3]), !xr & (s[0] | s[1])};
    return e;
  endfunction

  // Called one time unit after a clock edge; step is sampled at the next edge T.
  // Optionally re-triggers with st2 so that it is sampled at edge T+2.
  task automatic run_query(input logic [31:0] st, input bit retrig, input logic [31:0] st2);
    exp_t e, got;
    exp_q.push_back(model(st));
    e = model(st);
    playerState = st;
    step = 1'b1;
    @(posedge sim_clk); #1;
    step = 1'b0;
    chk("busy_T0", 32'(busy), 32'd0);
    for (int c = 1; c <= 8; c++) begin
      if (retrig && c == 2) begin
        playerState = st2;
        step = 1'b1;
      end
      if (c == 3) begin
        step = 1'b0;
        playerState = st;
      end
      @(posedge sim_clk); #1;
      if (c <= 4) begin
        chk("tile_re", 32'(tile_re), 32'(e.re[c-1]));
        if (e.re[c-1]) chk("tile_addr", 32'(tile_addr), 32'(e.addr[(c-1)*9 +: 9]));
      end
      chk("busy", 32'(busy), (c <= 5) ? 32'd1 : 32'd0);
      chk("col_valid", 32'(col_valid), (c == 6) ? 32'd1 : 32'd0);
      if (c == 6) begin
        if (exp_q.size() == 0) begin
          chk("queue_empty", 32'd1, 32'd0);
        end else begin
          got = exp_q.pop_front();
          chk("playerCol", 32'(playerCol), 32'(got.col));
        end
      end
      if (c == 8) chk("col_hold", 32'(playerCol), 32'(e.col));
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_col"},   32'(playerCol), 32'd0);
    chk({tag, "_valid"}, 32'(col_valid), 32'd0);
    chk({tag, "_busy"},  32'(busy),      32'd0);
    chk({tag, "_re"},    32'(tile_re),   32'd0);
    chk({tag, "_addr"},  32'(tile_addr), 32'd0);
  endtask

  initial begin
    logic [31:0] st_right, st_left, st_land, st_ceil;
    reset = 1'b1;
    step = 1'b0;
    playerState = '0;
    for (int i = 0; i < 300; i++) tmap[i] = 1'b0;
    tmap[42] = 1'b1;
    tmap[61] = 1'b1;
    st_right = mk(176, 99, 4, 0, 1'b1, 1'b0);
    st_left  = mk(146, 99, 4, 0, 1'b0, 1'b0);
    st_land  = mk(176, 99, 0, 5, 1'b0, 1'b0);
    st_ceil  = mk(176, 40, 0, 10, 1'b0, 1'b1);

    repeat (3) @(posedge sim_clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;
    @(posedge sim_clk); #1;

    // Right wall: tile 42 solid
    run_query(st_right, 1'b0, '0);
    chk("right_col", 32'(playerCol), 32'b0100);
    // Left field edge: nx=142 out of field
    run_query(st_left, 1'b0, '0);
    chk("left_col", 32'(playerCol), 32'b0001);
    // Landing on tile 61
    run_query(st_land, 1'b0, '0);
    chk("land_col", 32'(playerCol), 32'b0010);
    // Ceiling: ny=30 above the playfield
    run_query(st_ceil, 1'b0, '0);
    chk("ceil_col", 32'(playerCol), 32'b1000);
    // Second step while busy is ignored; result from the first state
    run_query(st_right, 1'b1, st_ceil);
    chk("retrig_col", 32'(playerCol), 32'b0100);

    // Reset mid-query: step at T, reset sampled at T+3, new step at T+5
    playerState = st_land;
    step = 1'b1;
    @(posedge sim_clk); #1;
    step = 1'b0;
    @(posedge sim_clk); #1;
    @(posedge sim_clk); #1;
    reset = 1'b1;
    @(posedge sim_clk); #1;
    check_all_zero("midreset");
    reset = 1'b0;
    @(posedge sim_clk); #1;
    chk("midreset_valid_T4", 32'(col_valid), 32'd0);
    run_query(st_ceil, 1'b0, '0);
    chk("after_reset_col", 32'(playerCol), 32'b1000);

    // Random map and random states, including wrap near the field edges
    for (int i = 0; i < 300; i++) tmap[i] = ($urandom_range(0, 2) == 0);
    for (int n = 0; n < 10; n++) begin
      run_query(mk($urandom_range(100, 820), $urandom_range(0, 560),
                   $urandom_range(0, 31), $urandom_range(0, 31),
                   1'($urandom), 1'($urandom)), 1'b0, '0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
